sobel_line_buffer: RTL
======================

// Module: sobel_line_buffer
// PURPOSE
//  Streaming 3x3 window generator directly upstream of the Sobel kernel.
//  Takes a raster pixel stream one pixel per accepted cycle, keeps the two previous lines in
//  two dualPortRam instances (clockA = clockB = clock), and presents a registered 3x3
//  neighbourhood plus a valid strobe to the gradient stage.
//  One window is produced per accepted pixel once two full lines and two columns are buffered.
// PARAMETERS
//  lineWidth  640  pixels per line; legal range >= 3; sets RAM depth and column counter range
//  pixelBits  8    bits per pixel; equals RAM entryLength
// PORTS
//  clock        in   1             single clock; both RAM ports on it
//  reset        in   1             synchronous, active-high
//  newFrame     in   1             1-cycle pulse: next accepted pixel is row 0, col 0
//  pixelValid   in   1             pixelIn is accepted this cycle; no backpressure
//  pixelIn      in   pixelBits     current raster pixel
//  windowValid  out  1             windowOut holds a complete window this cycle
//  windowOut    out  9*pixelBits   element (r,c) at [pixelBits*(3*r+c) +: pixelBits]; r=0 oldest row, c=0 oldest column
// BEHAVIOUR
//  Reset (sync, active-high):
//   - col, row, window registers, stage-1 registers and windowValid all clear to 0.
//   - An in-flight stage-1 pixel is discarded; RAM contents are not cleared.
//  Counters:
//   - col runs 0..lineWidth-1 and advances on each accepted pixel.
//   - At col = lineWidth-1 an accepted pixel wraps col to 0 and increments row.
//   - row is 2 bits and saturates at 2; only row >= 2 matters.
//  newFrame:
//   - Clears col and row synchronously; RAM and window contents are kept.
//   - newFrame with pixelValid in the same cycle: that pixel is accepted as row 0, col 0.
//  Stage 0, cycle t, pixelValid = 1:
//   - lineA (row-1) and lineB (row-2) are both read at addressOut = col.
//   - lineA[col] <= pixelIn.
//   - Register pixelIn, col, valid, and flag ok = (row == 2 && col >= 2).
//  Stage 1, cycle t+1, stage-1 valid:
//   - RAM dataOut is available.
//   - lineB[col_d] <= lineA dataOut. This is the old row-1 pixel: a read in the same cycle
//     as a write to that address returns the old data.
//   - Column vector {lineB out, lineA out, pixel_d} shifts into window column 2.
//   - Columns 2 -> 1 -> 0.
//   - windowValid <= ok_d, otherwise 0.
//  Output timing:
//   - windowValid and windowOut are registered and valid in cycle t+2 (latency 2 from accept).
//   - windowValid is a 1-cycle strobe per qualifying pixel.
//   - The window centre is pixel (row-1, col-1) relative to the accepted pixel.
//  Gaps in pixelValid:
//   - The pipeline simply idles; windowOut holds its value and windowValid = 0.
//   - The stage-1 lineB write still completes at t+1.
//  Collisions:
//   - At t+1, lineB is read at col+1 and written at col_d; lineWidth >= 3 guarantees these
//     addresses differ.
//  Edges:
//   - Cols 0,1 of each line and rows 0,1 of each frame never assert windowValid (no border padding).
//  Reset mid-operation:
//   - Any pending window strobe is dropped.
//   - The first frame after reset needs two full lines before any output.
// TESTING  (lineWidth=4 unless noted; pixel = 16*row+col)
//  1 Reset held 3 cycles, pixelValid=0 -> windowValid=0, windowOut=0 throughout.
//  2 newFrame, then 12 pixels back-to-back (3 rows):
//     - exactly 2 windowValid pulses, 2 cycles after pixels 0x22 and 0x23.
//     - first window rows {00,01,02},{10,11,12},{20,21,22}.
//  3 Same frame with random 0-3 idle cycles between pixels -> identical windows, same count;
//    windowOut stable while windowValid=0.
//  4 newFrame pulsed mid-row 2 -> no windowValid until new-frame pixel (2,2);
//    simultaneous newFrame+pixelValid is pixel (0,0).
//  5 reset asserted the cycle after pixel 0x22 is accepted -> no windowValid for it;
//    restart frame gives first window at new (2,2).
//  6 lineWidth=640, 480-line frame at full rate -> 478*638 windows;
//    every window equals a software 3x3 reference model.

Source files
------------

// File: rtl/sobel_line_buffer_if.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer_if
// Pixel-stream input and 3x3-window output of the Sobel line buffer, bundled so
// the producer and the window generator connect through one port.
//   newFrame     producer -> buffer  1-cycle pulse: next accepted pixel is (0,0)
//   pixelValid   producer -> buffer  pixelIn is accepted this cycle
//   pixelIn      producer -> buffer  current raster pixel
//   windowValid  buffer -> consumer  windowOut holds a complete window
//   windowOut    buffer -> consumer  (r,c) at [pixelBits*(3*r+c) +: pixelBits]
// master: pixel source / window sink. slave: the line buffer itself.
// -----------------------------------------------------------------------------
interface sobel_line_buffer_if #(
    parameter int pixelBits = 8
);
    logic                     newFrame;
    logic                     pixelValid;
    logic [pixelBits-1:0]     pixelIn;
    logic                     windowValid;
    logic [9*pixelBits-1:0]   windowOut;

    modport master (
        output newFrame,
        output pixelValid,
        output pixelIn,
        input  windowValid,
        input  windowOut
    );

    modport slave (
        input  newFrame,
        input  pixelValid,
        input  pixelIn,
        output windowValid,
        output windowOut
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// Streaming 3x3 window generator feeding the Sobel gradient stage. The two
// previous lines live in two dualPortRam instances (lineA = row-1,
// lineB = row-2). A window is emitted two cycles after each accepted pixel at
// row >= 2 and col >= 2 of the current frame; there is no border padding.
// Ports:
//   clock  single clock, both RAM ports run on it
//   reset  synchronous, active-high; clears counters, pipeline and window
//   bus    sobel_line_buffer_if.slave (pixel stream in, window out)
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int lineWidth = 640,
    parameter int pixelBits = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    sobel_line_buffer_if.slave    bus
);
    localparam int colBits = $clog2(lineWidth);
    localparam logic [colBits-1:0] lastCol = colBits'(lineWidth - 1);

    logic [colBits-1:0]   col_r;
    logic [1:0]           row_r;
    logic [colBits-1:0]   col_s;
    logic [1:0]           row_s;
    logic                 accept_s;
    logic                 ok_s;

    logic                 s1_valid_r;
    logic                 s1_ok_r;
    logic [colBits-1:0]   s1_col_r;
    logic [pixelBits-1:0] s1_pixel_r;
    logic                 s1_write_s;

    logic [pixelBits-1:0] line_a_q_s;
    logic [pixelBits-1:0] line_b_q_s;

    logic [pixelBits-1:0] win_r [0:8];
    logic                 window_valid_r;

    // Effective position of this cycle's pixel: newFrame forces it to (0,0).
    always_comb begin
        accept_s = bus.pixelValid & ~reset;
        if (bus.newFrame) begin
            col_s = '0;
            row_s = 2'd0;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
        ok_s       = (row_s == 2'd2) && (col_s >= colBits'(2));
        s1_write_s = s1_valid_r & ~reset;
    end

    // Raster position counters; row saturates at 2 since only row >= 2 matters.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r <= '0;
            row_r <= 2'd0;
        end else if (bus.pixelValid) begin
            if (col_s == lastCol) begin
                col_r <= '0;
                row_r <= (row_s == 2'd2) ? 2'd2 : row_s + 2'd1;
            end else begin
                col_r <= col_s + colBits'(1);
                row_r <= row_s;
            end
        end else if (bus.newFrame) begin
            col_r <= '0;
            row_r <= 2'd0;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Stage-1 pipeline registers; reset discards an in-flight pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_ok_r    <= 1'b0;
            s1_col_r   <= '0;
            s1_pixel_r <= '0;
        end else if (bus.pixelValid) begin
            s1_valid_r <= 1'b1;
            s1_ok_r    <= ok_s;
            s1_col_r   <= col_s;
            s1_pixel_r <= bus.pixelIn;
        end else begin
            s1_valid_r <= 1'b0;
            s1_ok_r    <= s1_ok_r;
            s1_col_r   <= s1_col_r;
            s1_pixel_r <= s1_pixel_r;
        end
    end

    // lineA holds row-1: written with the new pixel while its old value is read.
    dualPortRam #(.depth(lineWidth), .addressLength(colBits), .entryLength(pixelBits)) line_a (
        .clockA      (clock),
        .writeEnable (accept_s),
        .addressIn   (col_s),
        .dataIn      (bus.pixelIn),
        .clockB      (clock),
        .addressOut  (col_s),
        .dataOut     (line_a_q_s)
    );

    // lineB holds row-2: one cycle later it takes the old row-1 pixel read from
    // lineA. Its write (col_d) never meets its read (col+1) while lineWidth >= 3.
    dualPortRam #(.depth(lineWidth), .addressLength(colBits), .entryLength(pixelBits)) line_b (
        .clockA      (clock),
        .writeEnable (s1_write_s),
        .addressIn   (s1_col_r),
        .dataIn      (line_a_q_s),
        .clockB      (clock),
        .addressOut  (col_s),
        .dataOut     (line_b_q_s)
    );

    // Window shift: new column {row-2, row-1, pixel} enters column 2, 2->1->0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= '0;
            end
            window_valid_r <= 1'b0;
        end else if (s1_valid_r) begin
            for (int r = 0; r < 3; r++) begin
                win_r[3*r]   <= win_r[3*r+1];
                win_r[3*r+1] <= win_r[3*r+2];
            end
            win_r[2]       <= line_b_q_s;
            win_r[5]       <= line_a_q_s;
            win_r[8]       <= s1_pixel_r;
            window_valid_r <= s1_ok_r;
        end else begin
            window_valid_r <= 1'b0;
        end
    end

    // Pack the registered window onto the output bus.
    always_comb begin
        bus.windowOut = '0;
        for (int i = 0; i < 9; i++) begin
            bus.windowOut[pixelBits*i +: pixelBits] = win_r[i];
        end
        bus.windowValid = window_valid_r;
    end
endmodule

// -----------------------------------------------------------------------------
// dualPortRam
// Simple dual-port RAM: write port on clockA, registered read port on clockB.
// A read of an address being written in the same cycle returns the old data.
// Contents are never reset.
// -----------------------------------------------------------------------------
module dualPortRam #(
    parameter int depth         = 640,
    parameter int addressLength = 10,
    parameter int entryLength   = 8
) (
    input  logic                     clockA,
    input  logic                     writeEnable,
    input  logic [addressLength-1:0] addressIn,
    input  logic [entryLength-1:0]   dataIn,
    input  logic                     clockB,
    input  logic [addressLength-1:0] addressOut,
    output logic [entryLength-1:0]   dataOut
);
    logic [entryLength-1:0] mem_r [0:depth-1];

    // Write port.
    always_ff @(posedge clockA) begin
        if (writeEnable) begin
            mem_r[addressIn] <= dataIn;
        end
    end

    // Registered read port (old data on a same-address write).
    always_ff @(posedge clockB) begin
        dataOut <= mem_r[addressOut];
    end
endmodule
